// File: rtl/keypad_scanner_pkg.sv
// Shared key codes and decode helpers for the keypad scanner and the calculator control FSM.
// Codes 0x00-0x0F are hex digits; KEY_NONE marks "no key held".
package keypad_scanner_pkg;

  localparam int KEY_W = 5;
  typedef logic [KEY_W-1:0] key_t;

  localparam key_t KEY_0    = 5'h00;
  localparam key_t KEY_1    = 5'h01;
  localparam key_t KEY_2    = 5'h02;
  localparam key_t KEY_3    = 5'h03;
  localparam key_t KEY_4    = 5'h04;
  localparam key_t KEY_5    = 5'h05;
  localparam key_t KEY_6    = 5'h06;
  localparam key_t KEY_7    = 5'h07;
  localparam key_t KEY_8    = 5'h08;
  localparam key_t KEY_9    = 5'h09;
  localparam key_t KEY_A    = 5'h0A;
  localparam key_t KEY_B    = 5'h0B;
  localparam key_t KEY_C    = 5'h0C;
  localparam key_t KEY_D    = 5'h0D;
  localparam key_t KEY_E    = 5'h0E;
  localparam key_t KEY_F    = 5'h0F;
  localparam key_t KEY_NONE = 5'h10;

  // Lowest pressed row wins within a column.
  function automatic logic [1:0] first_row(input logic [3:0] pressed);
    if (pressed[0]) return 2'd0;
    if (pressed[1]) return 2'd1;
    if (pressed[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic key_t key_decode(input logic [1:0] row, input logic [1:0] col);
    key_t k;
    case ({row, col})
      4'b00_00: k = KEY_1;
      4'b00_01: k = KEY_2;
      4'b00_10: k = KEY_3;
      4'b00_11: k = KEY_A;
      4'b01_00: k = KEY_4;
      4'b01_01: k = KEY_5;
      4'b01_10: k = KEY_6;
      4'b01_11: k = KEY_B;
      4'b10_00: k = KEY_7;
      4'b10_01: k = KEY_8;
      4'b10_10: k = KEY_9;
      4'b10_11: k = KEY_C;
      4'b11_00: k = KEY_E;
      4'b11_01: k = KEY_0;
      4'b11_10: k = KEY_F;
      default:  k = KEY_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-output signals of the scanner; master is the scanner itself,
// slave is the keypad matrix plus the key consumer.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [3:0] row_n;
  logic [3:0] col_n;
  key_t       key;
  logic       key_new;

  modport master (input row_n, output col_n, output key, output key_new);
  modport slave  (output row_n, input col_n, input key, input key_new);

endinterface

// File: rtl/keypad_scanner_key_debouncer.sv
// Frame-rate debouncer: key follows the frame candidate once it has been identical for
// DEBOUNCE_FRAMES consecutive frames; key_new pulses for one cycle on each update.
module key_debouncer
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_end_i,
  input  key_t cand_i,
  output key_t key_o,
  output logic key_new_o
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  key_t          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  key_t          key_q, key_d;
  logic          key_new_q, key_new_d;

  always_comb begin
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_new_d = 1'b0;
    if (frame_end_i) begin
      prev_d = cand_i;
      if (cand_i == prev_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = CW'(1);
      end
      if (cnt_d == CNT_MAX && cand_i != key_q) begin
        key_d     = cand_i;
        key_new_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= KEY_NONE;
      cnt_q     <= '0;
      key_q     <= KEY_NONE;
      key_new_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      key_new_q <= key_new_d;
    end
  end

  assign key_o     = key_q;
  assign key_new_o = key_new_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one column low per SCAN_DIV cycles, samples the
// synchronized rows at the end of each dwell and forms a per-frame scan-order candidate.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  key_t          cand_q, cand_d;
  key_t          col_cand, frame_cand;
  logic          col_last, frame_end;
  logic [3:0]    pressed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= kp.row_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    pressed  = ~sync2_q;
    col_last = (dwell_q == DW'(SCAN_DIV - 1));
    frame_end = col_last && (col_q == 2'd3);
    dwell_d  = col_last ? '0 : dwell_q + 1'b1;
    col_d    = col_last ? col_q + 2'd1 : col_q;
    col_cand = (|pressed) ? key_decode(first_row(pressed), col_q) : KEY_NONE;
    // Column 0 starts a fresh frame; later columns only fill in if nothing was found yet.
    frame_cand = (col_q == 2'd0 || cand_q == KEY_NONE) ? col_cand : cand_q;
    cand_d   = col_last ? frame_cand : cand_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      col_q   <= 2'd0;
      cand_q  <= KEY_NONE;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
    end
  end

  assign kp.col_n = ~(4'b0001 << col_q);

  key_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .frame_end_i(frame_end),
    .cand_i     (frame_cand),
    .key_o      (kp.key),
    .key_new_o  (kp.key_new)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed frame-level checks of keypad_scanner against a history-based
// debounce model and a behavioural keypad matrix.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FRAME = 4 * SD;
  localparam logic [4:0] NONE = 5'h10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  // Keypad matrix: a held key at (r,c) pulls row r low while column c is driven low.
  logic [15:0] held;
  always_comb begin
    kp.row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
  end

  int total = 0;
  int bad = 0;
  logic [4:0] kmap [16];
  logic [4:0] hist [$];
  logic [4:0] mkey;
  bit pulse_due;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_cand(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4+c]) return kmap[r*4+c];
    return NONE;
  endfunction

  task automatic model_reset();
    hist.delete();
    mkey = NONE;
    pulse_due = 1'b0;
  endtask

  // key follows the candidate once the last DF frame candidates agree.
  task automatic model_frame(input logic [4:0] cand);
    bit same;
    hist.push_back(cand);
    if (hist.size() > DF) void'(hist.pop_front());
    same = (hist.size() == DF);
    foreach (hist[i]) if (hist[i] != cand) same = 1'b0;
    if (same && cand != mkey) begin
      mkey = cand;
      pulse_due = 1'b1;
    end
  endtask

  // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of the next.
  task automatic run_frame(input logic [15:0] mask);
    logic [3:0] exp_col;
    held = mask;
    for (int i = 0; i < FRAME; i++) begin
      exp_col = ~(4'b0001 << (i / SD));
      check("col_n", kp.col_n, exp_col);
      check("key", kp.key, mkey);
      check("key_new", kp.key_new, (i == 0) && pulse_due);
      if (i == 0) pulse_due = 1'b0;
      @(negedge clk);
    end
    model_frame(ref_cand(mask));
  endtask

  task automatic mid_reset(input int at);
    for (int i = 0; i < at; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_key", kp.key, NONE);
    check("rst_col", kp.col_n, 4'b1110);
    check("rst_new", kp.key_new, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    case ($urandom_range(0, 3))
      0: m = '0;
      1: m = 16'(1) << $urandom_range(0, 15);
      2: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      default: m = 16'($urandom);
    endcase
    return m;
  endfunction

  initial begin
    kmap = '{5'h1, 5'h2, 5'h3, 5'hA,
             5'h4, 5'h5, 5'h6, 5'hB,
             5'h7, 5'h8, 5'h9, 5'hC,
             5'hE, 5'h0, 5'hF, 5'hD};
    held = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_col", kp.col_n, 4'b1110);
    check("reset_key", kp.key, NONE);
    check("reset_new", kp.key_new, 1'b0);
    rst = 1'b0;

    // Idle scanning
    repeat (3) run_frame('0);
    check("s1_key", kp.key, 5'h10);

    // Key 6 held then released
    repeat (4) run_frame(16'(1) << 6);
    check("s2_press", kp.key, 5'h06);
    repeat (4) run_frame('0);
    check("s2_release", kp.key, 5'h10);

    // Key 1 held too briefly
    repeat (2) run_frame(16'(1) << 0);
    repeat (4) run_frame('0);
    check("s3_short", kp.key, 5'h10);

    // 9 and D together, then D alone
    repeat (4) run_frame((16'(1) << 10) | (16'(1) << 15));
    check("s4_multi", kp.key, 5'h09);
    repeat (4) run_frame(16'(1) << 15);
    check("s4_roll", kp.key, 5'h0D);
    repeat (4) run_frame('0);

    // Key 0 bouncing, then steady
    for (int k = 0; k < 6; k++) run_frame((k % 2 == 0) ? (16'(1) << 13) : 16'h0);
    check("s5_bounce", kp.key, 5'h10);
    repeat (4) run_frame(16'(1) << 13);
    check("s5_steady", kp.key, 5'h00);
    repeat (4) run_frame('0);

    // Reset mid-frame while key 5 is reported
    repeat (4) run_frame(16'(1) << 5);
    check("s6_pre", kp.key, 5'h05);
    mid_reset(6);
    repeat (4) run_frame(16'(1) << 5);
    check("s6_post", kp.key, 5'h05);

    // Random held-key sequences
    for (int n = 0; n < 30; n++) begin
      logic [15:0] m;
      m = rand_mask();
      repeat ($urandom_range(1, 4)) run_frame(m);
      if (n == 15) mid_reset($urandom_range(1, FRAME - 1));
    end
    repeat (4) run_frame('0);
    check("final_idle", kp.key, 5'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, giving the clk cycles each column is driven (minimum 4).
REQ-002 The block SHALL have parameter DEBOUNCE_FRAMES, default 4, giving the consecutive identical frames required before the key output changes (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit, system clock.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port row_n, input, 4 bits, keypad rows, active-low, asynchronous to clk.
REQ-006 The block SHALL have port col_n, output, 4 bits, keypad column drive, active-low, exactly one bit low at any time.
REQ-007 The block SHALL have port key, output, 5 bits, debounced key code: 0x00-0x0F for hex keys, KEY_NONE (0x10) when no key is pressed.
REQ-008 The block SHALL have port key_new, output, 1 bit, one-cycle pulse on any change of key, including a change to KEY_NONE.

Function
REQ-009 row_n SHALL pass through a 2-flop synchronizer before any use.
REQ-010 Column c (c = 0..3) SHALL be driven low for SCAN_DIV cycles, rotating 0->1->2->3->0; one full rotation is one frame (4*SCAN_DIV cycles).
REQ-011 Synchronized rows SHALL be sampled only on the last cycle of each column's dwell period.
REQ-012 The key at row r, column c SHALL map to: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-013 Each frame's candidate SHALL be the first pressed key in scan order (column ascending, then row ascending within a column), or KEY_NONE if no key is pressed.
REQ-014 At each frame end, if the candidate equals the previous frame's candidate, stable_cnt SHALL increment, saturating at DEBOUNCE_FRAMES; otherwise stable_cnt SHALL be set to 1.
REQ-015 key SHALL be loaded with the candidate on the clock after a frame end at which stable_cnt equals DEBOUNCE_FRAMES and the candidate differs from key.
REQ-016 key_new SHALL be high for exactly that one cycle; no pulse SHALL occur while key is unchanged.
REQ-017 key SHALL change only at frame boundaries and SHALL hold its value between them.
REQ-018 A direct change from one key to another without an intervening KEY_NONE SHALL produce a single update and a single key_new pulse.
REQ-019 With multiple keys held, key SHALL report the scan-order winner only, and stable_cnt SHALL not restart while that winner is unchanged.
REQ-020 The dwell counter SHALL wrap from SCAN_DIV-1 to 0 and the column index SHALL wrap from 3 to 0, with no idle cycle.

Reset
REQ-021 Reset SHALL set: col_n = 4'b1110; key = KEY_NONE; key_new = 0; dwell counter = 0; column index = 0; candidate and previous candidate = KEY_NONE; stable_cnt = 0; synchronizer flops = 4'b1111.
REQ-022 Reset asserted mid-frame SHALL abandon the partial frame, and scanning SHALL restart at column 0 on the first clock after release.

Structure
REQ-023 KEY_NONE and the key codes 0x0-0xF SHALL live in the shared defines header used by the calculator control state machine.
REQ-024 The debounce logic (candidate compare, stable_cnt, key/key_new registers) SHALL be a sub-module named key_debouncer; scanning and decoding SHALL remain in keypad_scanner.
REQ-025 key SHALL connect directly to the control state machine's key input with no further registering.

Verification
REQ-026 All scenarios SHALL use SCAN_DIV = 4 and DEBOUNCE_FRAMES = 3 (frame = 16 cycles).
REQ-027 Scenario 1: idle after reset -> col_n cycles 1110, 1101, 1011, 0111 every 4 clocks; key = 0x10; key_new never pulses.
REQ-028 Scenario 2: hold r1/c2 (key 6) from the start of a frame -> key = 0x06 and a single key_new pulse after the 3rd frame end; release -> key = 0x10 and one pulse 3 frames later.
REQ-029 Scenario 3: hold r0/c0 (key 1) for 2 frames only -> key stays 0x10 with no pulse.
REQ-030 Scenario 4: hold key 9 (r2/c2) and key D (r3/c3) together -> key = 0x09; release 9 while D is held -> key = 0x0D with exactly one pulse and no intermediate 0x10.
REQ-031 Scenario 5: bounce r3/c1 (key 0) on alternate frames for 6 frames, then hold steady -> no update until 3 stable frames, then key = 0x00.
REQ-032 Scenario 6: assert rst for 1 cycle mid-frame while key = 0x05 -> key = 0x10 and col_n = 1110 immediately; scanning restarts at column 0.
